// File: rtl/mem_stage_pipe.sv
// Memory stage: byte-lane data RAM, UART transmit queue and status as MMIO,
// and one registered writeback stage with a misaligned-access exception.
module mem_stage_lane #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] idx,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)    mem[idx] <= wdata;
        if (rd_en) rdata <= mem[idx];
    end
endmodule

module mem_stage_pipe #(
    parameter int          ADDR_W         = 10,
    parameter int          TXQ_DEPTH      = 8,
    parameter logic [31:0] UART_TXD_ADDR  = 32'h4000_0018,
    parameter logic [31:0] UART_STAT_ADDR = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        stall,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] ALUOut,
    input  logic [31:0] DataBusB,
    input  logic [31:0] NewPC,
    input  logic [1:0]  MemToReg,
    input  logic        RegWr,
    input  logic [4:0]  RegAddr,
    output logic        wb_valid,
    output logic        wb_RegWr,
    output logic [4:0]  wb_RegAddr,
    output logic [31:0] WriteData,
    output logic        exc,
    output logic [31:0] exc_addr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int NUM_LANES = 4;
    localparam int PW = $clog2(TXQ_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] SRC_RAM  = 2'd0;
    localparam logic [1:0] SRC_STAT = 2'd1;
    localparam logic [1:0] SRC_NONE = 2'd2;

    typedef struct packed {
        logic [1:0]  mem_to_reg;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  src;
        logic [7:0]  stat;
        logic [31:0] alu_out;
        logic [31:0] new_pc;
    } wb_req_t;

    logic is_half, is_word, misaligned, in_ram, hit_txd, hit_stat;
    logic accept, do_store, rd_en, push, pop;
    logic q_full, q_empty;
    logic [PW-1:0] q_wp, q_rp;
    logic [CW-1:0] q_cnt;
    logic [7:0]    q_mem [TXQ_DEPTH];
    logic [7:0]    stat_now;
    wb_req_t       s1;

    assign is_half    = MemSize == 2'b01;
    assign is_word    = MemSize[1];
    assign misaligned = (MemRd || MemWr) &&
                        ((is_half && ALUOut[0]) || (is_word && ALUOut[1:0] != 2'b00));
    assign in_ram     = ALUOut[31:ADDR_W+2] == '0;
    assign hit_txd    = ALUOut == UART_TXD_ADDR;
    assign hit_stat   = ALUOut == UART_STAT_ADDR;

    assign q_full   = q_cnt == CW'(TXQ_DEPTH);
    assign q_empty  = q_cnt == '0;
    assign stat_now = {1'b0, 5'(q_cnt), q_empty, q_full};

    // Only a push into a full queue can hold the pipe; a pop this cycle is not forwarded.
    assign stall    = in_valid && MemWr && hit_txd && q_full;
    assign accept   = in_valid && !stall;
    assign do_store = accept && MemWr && !misaligned;
    assign rd_en    = accept && MemRd && !MemWr && !misaligned && in_ram;
    assign push     = do_store && hit_txd;
    assign pop      = tx_valid && tx_ready;

    logic [NUM_LANES-1:0]      lane_we;
    logic [NUM_LANES-1:0][7:0] lane_wdata, lane_rdata;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_we[i] = do_store && in_ram &&
                         (is_word || (is_half ? ((i / 2) == int'(ALUOut[1]))
                                              : (i == int'(ALUOut[1:0]))));
            if (is_word)      lane_wdata[i] = DataBusB[8*i +: 8];
            else if (is_half) lane_wdata[i] = DataBusB[8*(i%2) +: 8];
            else              lane_wdata[i] = DataBusB[7:0];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            mem_stage_lane #(.ADDR_W(ADDR_W)) u_lane (
                .clk   (clk),
                .we    (lane_we[g]),
                .rd_en (rd_en),
                .idx   (ALUOut[ADDR_W+1:2]),
                .wdata (lane_wdata[g]),
                .rdata (lane_rdata[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_wp  <= '0;
            q_rp  <= '0;
            q_cnt <= '0;
        end else begin
            if (push) q_wp <= q_wp + PW'(1);
            if (pop)  q_rp <= q_rp + PW'(1);
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + CW'(1);
                2'b01:   q_cnt <= q_cnt - CW'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[q_wp] <= DataBusB[7:0];
    end

    assign tx_valid = !q_empty;
    assign tx_data  = q_mem[q_rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid   <= 1'b0;
            wb_RegWr   <= 1'b0;
            wb_RegAddr <= '0;
            exc        <= 1'b0;
            exc_addr   <= '0;
            s1         <= '0;
        end else begin
            wb_valid <= accept;
            wb_RegWr <= accept && RegWr && !misaligned;
            exc      <= accept && misaligned;
            if (accept) begin
                wb_RegAddr    <= RegAddr;
                s1.mem_to_reg <= MemToReg;
                s1.size       <= MemSize;
                s1.sgn        <= MemSigned;
                s1.stat       <= stat_now;
                s1.alu_out    <= ALUOut;
                s1.new_pc     <= NewPC;
                if (MemWr || misaligned) s1.src <= SRC_NONE;
                else if (hit_stat)       s1.src <= SRC_STAT;
                else if (in_ram)         s1.src <= SRC_RAM;
                else                     s1.src <= SRC_NONE;
                if (misaligned) exc_addr <= ALUOut;
            end
        end
    end

    logic [31:0] raw_word, ld_data;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;

    // Lane select and extension on the registered side, after the synchronous RAM read.
    always_comb begin
        case (s1.src)
            SRC_RAM:  raw_word = lane_rdata;
            SRC_STAT: raw_word = {24'b0, s1.stat};
            default:  raw_word = '0;
        endcase
        ld_half = s1.alu_out[1] ? raw_word[31:16] : raw_word[15:0];
        ld_byte = raw_word[{s1.alu_out[1:0], 3'b000} +: 8];
        if (s1.size[1])          ld_data = raw_word;
        else if (s1.size[0])     ld_data = {{16{s1.sgn & ld_half[15]}}, ld_half};
        else                     ld_data = {{24{s1.sgn & ld_byte[7]}}, ld_byte};
        case (s1.mem_to_reg)
            2'b00:   WriteData = s1.alu_out;
            2'b01:   WriteData = ld_data;
            2'b10:   WriteData = s1.new_pc;
            default: WriteData = {s1.alu_out[15:0], 16'b0};
        endcase
    end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: RAM lanes, misalignment, MMIO queue, reset.
module tb_mem_stage_pipe;
    localparam logic [31:0] TXD  = 32'h4000_0018;
    localparam logic [31:0] STAT = 32'h4000_0020;
    localparam logic [1:0]  SZB = 2'b00, SZH = 2'b01, SZW = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, stall, MemRd, MemWr, MemSigned, RegWr;
    logic [1:0]  MemSize, MemToReg;
    logic [31:0] ALUOut, DataBusB, NewPC;
    logic [4:0]  RegAddr;
    logic        wb_valid, wb_RegWr, exc, tx_valid, tx_ready;
    logic [4:0]  wb_RegAddr;
    logic [31:0] WriteData, exc_addr;
    logic [7:0]  tx_data;

    int n_cmp = 0;
    int n_bad = 0;
    byte unsigned expq[$];

    always #5 clk = ~clk;

    mem_stage_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
        .MemRd(MemRd), .MemWr(MemWr), .MemSize(MemSize), .MemSigned(MemSigned),
        .ALUOut(ALUOut), .DataBusB(DataBusB), .NewPC(NewPC), .MemToReg(MemToReg),
        .RegWr(RegWr), .RegAddr(RegAddr), .wb_valid(wb_valid), .wb_RegWr(wb_RegWr),
        .wb_RegAddr(wb_RegAddr), .WriteData(WriteData), .exc(exc), .exc_addr(exc_addr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] m2r, input logic rw, input logic [4:0] ra);
        in_valid = 1'b1; MemRd = rd; MemWr = wr; MemSize = sz; MemSigned = sg;
        ALUOut = addr; DataBusB = data; MemToReg = m2r; RegWr = rw; RegAddr = ra;
    endtask

    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic [1:0] m2r, input logic rw, input logic [4:0] ra);
        set_op(rd, wr, sz, sg, addr, data, m2r, rw, ra);
        tick();
        idle();
    endtask

    task automatic ld(input logic [31:0] addr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] exp, input string tag);
        op(1'b1, 1'b0, sz, sg, addr, 32'h0, 2'b01, 1'b1, 5'd3);
        chk(tag, WriteData, exp);
    endtask

    initial begin
        reset = 1'b1; tx_ready = 1'b0; NewPC = 32'h0;
        set_op(1'b0, 1'b0, SZW, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0);
        idle();
        tick(); tick();
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_regwr", wb_RegWr, 0);
        chk("rst_exc", exc, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_exc_addr", exc_addr, 0);
        chk("rst_wb_regaddr", wb_RegAddr, 0);
        reset = 1'b0;
        tick();

        // RAM lanes, sign/zero extension, store-then-load
        op(1'b0, 1'b1, SZW, 1'b0, 32'h10, 32'h1234_5678, 2'b00, 1'b0, 5'd0);
        chk("sw_wb_valid", wb_valid, 1);
        chk("sw_exc", exc, 0);
        tick();
        chk("idle_wb_valid", wb_valid, 0);
        ld(32'h13, SZB, 1'b1, 32'h0000_0012, "lb_13");
        chk("lb_regwr", wb_RegWr, 1);
        chk("lb_regaddr", wb_RegAddr, 3);
        op(1'b0, 1'b1, SZB, 1'b0, 32'h11, 32'h0000_00FF, 2'b00, 1'b0, 5'd0);
        ld(32'h11, SZB, 1'b1, 32'hFFFF_FFFF, "lb_11_after_sb");
        ld(32'h10, SZH, 1'b0, 32'h0000_FF78, "lhu_10");
        ld(32'h12, SZH, 1'b1, 32'h0000_1234, "lh_12");
        ld(32'h10, SZW, 1'b0, 32'h1234_FF78, "lw_10");
        op(1'b0, 1'b1, SZH, 1'b0, 32'h12, 32'h0000_ABCD, 2'b00, 1'b0, 5'd0);
        ld(32'h12, SZH, 1'b1, 32'hFFFF_ABCD, "lh_12_neg");
        ld(32'h10, SZW, 1'b0, 32'hABCD_FF78, "lw_after_sh");

        // Misaligned accesses
        op(1'b1, 1'b0, SZW, 1'b0, 32'h6, 32'h0, 2'b01, 1'b1, 5'd7);
        chk("mis_exc", exc, 1);
        chk("mis_exc_addr", exc_addr, 32'h6);
        chk("mis_regwr", wb_RegWr, 0);
        chk("mis_wb_valid", wb_valid, 1);
        tick();
        chk("mis_exc_pulse", exc, 0);
        op(1'b0, 1'b1, SZW, 1'b0, 32'h12, 32'hDEAD_BEEF, 2'b00, 1'b0, 5'd0);
        chk("mis_sw_exc_addr", exc_addr, 32'h12);
        op(1'b0, 1'b1, SZH, 1'b0, 32'h11, 32'h0000_5555, 2'b00, 1'b0, 5'd0);
        chk("mis_sh_exc", exc, 1);
        ld(32'h10, SZW, 1'b0, 32'hABCD_FF78, "lw_after_mis");

        // Rd+Wr together is a store; unmapped stores are dropped
        op(1'b1, 1'b1, SZW, 1'b0, 32'h14, 32'h55AA_33CC, 2'b01, 1'b1, 5'd9);
        chk("rdwr_regwr", wb_RegWr, 1);
        chk("rdwr_exc", exc, 0);
        ld(32'h14, SZW, 1'b0, 32'h55AA_33CC, "lw_14");
        op(1'b0, 1'b1, SZW, 1'b0, 32'h8000_0010, 32'h1111_1111, 2'b00, 1'b0, 5'd0);
        chk("unmapped_sw_exc", exc, 0);
        ld(32'h10, SZW, 1'b0, 32'hABCD_FF78, "lw_no_alias");
        ld(32'h8000_0010, SZW, 1'b0, 32'h0, "lw_unmapped");

        // Writeback source select
        NewPC = 32'h0040_0008;
        op(1'b0, 1'b0, SZW, 1'b0, 32'h0, 32'h0, 2'b10, 1'b1, 5'd31);
        chk("m2r_newpc", WriteData, 32'h0040_0008);
        op(1'b0, 1'b0, SZW, 1'b0, 32'h1234, 32'h0, 2'b11, 1'b1, 5'd1);
        chk("m2r_lui", WriteData, 32'h1234_0000);
        op(1'b0, 1'b0, SZW, 1'b0, 32'hCAFE_0001, 32'h0, 2'b00, 1'b1, 5'd1);
        chk("m2r_alu", WriteData, 32'hCAFE_0001);

        // Fill the queue with the UART held off
        ld(STAT, SZW, 1'b0, 32'h0000_0002, "stat_empty");
        for (int i = 0; i < 8; i++)
            op(1'b0, 1'b1, SZB, 1'b0, TXD, 32'(8'hA0 + i), 2'b00, 1'b0, 5'd0);
        chk("fill_tx_valid", tx_valid, 1);
        chk("fill_head", tx_data, 8'hA0);
        ld(STAT, SZW, 1'b0, 32'h0000_0021, "stat_full");
        set_op(1'b0, 1'b1, SZB, 1'b0, TXD, 32'h0000_00A8, 2'b00, 1'b0, 5'd0);
        #1;
        chk("stall_full", stall, 1);
        tx_ready = 1'b1;
        #1;
        chk("stall_with_pop", stall, 1);
        tick();
        tx_ready = 1'b0;
        chk("stalled_wb_valid", wb_valid, 0);
        chk("head_after_pop", tx_data, 8'hA1);
        chk("stall_released", stall, 0);
        tick();
        idle();
        chk("ninth_accepted", wb_valid, 1);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", tx_data, 32'(8'hA0 + i));
            tick();
        end
        tx_ready = 1'b0;
        chk("drained_tx_valid", tx_valid, 0);

        // Half-full queue with push and pop every cycle
        expq.delete();
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b1, SZB, 1'b0, TXD, 32'(8'hB0 + i), 2'b00, 1'b0, 5'd0);
            expq.push_back(8'(8'hB0 + i));
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_op(1'b0, 1'b1, SZB, 1'b0, TXD, 32'(8'hC0 + i), 2'b00, 1'b0, 5'd0);
            #1;
            chk("pp_stall", stall, 0);
            chk("pp_head", tx_data, expq[0]);
            tick();
            void'(expq.pop_front());
            expq.push_back(8'(8'hC0 + i));
        end
        idle();
        tx_ready = 1'b0;
        ld(STAT, SZW, 1'b0, 32'h0000_0010, "stat_pp_count");
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain", tx_data, expq[i]);
            tick();
        end
        tx_ready = 1'b0;
        chk("pp_empty", tx_valid, 0);

        // Reset in the middle of traffic
        for (int i = 0; i < 3; i++)
            op(1'b0, 1'b1, SZB, 1'b0, TXD, 32'(8'hD0 + i), 2'b00, 1'b0, 5'd0);
        chk("pre_rst_tx_valid", tx_valid, 1);
        set_op(1'b1, 1'b0, SZW, 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 5'd4);
        tick();
        chk("pre_rst_wb_valid", wb_valid, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_wdata", WriteData, 0);
        idle();
        tick();
        reset = 1'b0;
        ld(STAT, SZW, 1'b0, 32'h0000_0002, "stat_after_rst");
        chk("post_rst_tx_valid", tx_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
